// File: rtl/chan_reconfig_ctrl.sv
// chan_reconfig_ctrl
//
// Reconfigures the FFT size of a downstream input buffer without losing
// samples. A size request accepted in RUN closes the upstream stream, waits
// for the buffer output to go quiet (or for a drain timeout), applies the new
// size while pulsing the buffer reset, waits a settle period and reopens.
//
// Handshake semantics (all streams and the cfg port): a word moves on a
// rising clk edge where valid and ready are both 1; valid never depends on
// ready on the same interface, and ready is gated only by the registered state.
//
// Ports
//   clk, sync_reset_n           clock, asynchronous active-low reset
//   cfg_valid/cfg_fft_size/cfg_ready   size request port
//   s_axis_*                    upstream stream (slave side)
//   buf_s_axis_*                stream towards the input buffer
//   buf_m_axis_tvalid/tready    buffer output activity, observed only
//   buf_sync_reset              active-high reset to the buffer
//   fft_size                    size applied to the buffer
//   busy                        1 whenever the FSM is not in RUN
//   cfg_error                   one-cycle pulse after an invalid request
//   drain_timeout               sticky, set when DRAIN ended on its timer
//   state                       current FSM state (debug)
module chan_reconfig_ctrl #(
    parameter int DATA_WIDTH       = 32,
    parameter int FFT_SIZE_WIDTH   = 12,
    parameter int DEFAULT_FFT_SIZE = 64,
    parameter int RST_CYCLES       = 4,
    parameter int SETTLE_CYCLES    = 8,
    parameter int IDLE_CYCLES      = 16,
    parameter int DRAIN_TIMEOUT    = 4096
) (
    input  logic                      clk,
    input  logic                      sync_reset_n,
    input  logic                      cfg_valid,
    input  logic [FFT_SIZE_WIDTH-1:0] cfg_fft_size,
    output logic                      cfg_ready,
    input  logic                      s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    output logic                      s_axis_tready,
    output logic                      buf_s_axis_tvalid,
    output logic [DATA_WIDTH-1:0]     buf_s_axis_tdata,
    input  logic                      buf_s_axis_tready,
    input  logic                      buf_m_axis_tvalid,
    input  logic                      buf_m_axis_tready,
    output logic                      buf_sync_reset,
    output logic [FFT_SIZE_WIDTH-1:0] fft_size,
    output logic                      busy,
    output logic                      cfg_error,
    output logic                      drain_timeout,
    output logic [1:0]                state
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_RESET  = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    localparam int IDLE_W    = $clog2(IDLE_CYCLES + 1);
    localparam int DRAIN_W   = $clog2(DRAIN_TIMEOUT + 1);
    localparam int PHASE_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

    localparam logic [IDLE_W-1:0]         IDLE_LIMIT  = IDLE_W'(IDLE_CYCLES);
    localparam logic [DRAIN_W-1:0]        DRAIN_LIMIT = DRAIN_W'(DRAIN_TIMEOUT);
    localparam logic [PHASE_W-1:0]        RST_LAST    = PHASE_W'(RST_CYCLES - 1);
    localparam logic [PHASE_W-1:0]        SETTLE_LAST = PHASE_W'(SETTLE_CYCLES - 1);
    localparam logic [FFT_SIZE_WIDTH-1:0] SIZE_DEF    = FFT_SIZE_WIDTH'(DEFAULT_FFT_SIZE);
    localparam logic [FFT_SIZE_WIDTH-1:0] SIZE_MIN    = FFT_SIZE_WIDTH'(8);
    localparam logic [FFT_SIZE_WIDTH-1:0] SIZE_ONE    = FFT_SIZE_WIDTH'(1);
    localparam logic [FFT_SIZE_WIDTH-1:0] SIZE_MAX    = {1'b1, {(FFT_SIZE_WIDTH-1){1'b0}}};

    state_t                      state_q;
    logic [FFT_SIZE_WIDTH-1:0]   pending_q;
    logic [IDLE_W-1:0]           idle_cnt;
    logic [DRAIN_W-1:0]          drain_cnt;
    logic [PHASE_W-1:0]          phase_cnt;

    logic                        run;
    logic                        size_ok;
    logic [IDLE_W-1:0]           idle_nxt;
    logic [DRAIN_W-1:0]          drain_nxt;
    logic                        unused_ok;

    // Buffer output ready is not needed: only output valid signals activity.
    assign unused_ok = buf_m_axis_tready;

    // Traffic gating decodes the registered state only, so no combinational
    // path exists from cfg_valid to the stream handshake.
    assign run               = (state_q == ST_RUN);
    assign cfg_ready         = run;
    assign s_axis_tready     = run & buf_s_axis_tready;
    assign buf_s_axis_tvalid = run & s_axis_tvalid;
    assign buf_s_axis_tdata  = s_axis_tdata;
    assign state             = state_q;

    // Power of two within [8, 2^(W-1)]; the lower bound also rejects zero.
    always_comb begin
        size_ok = ((cfg_fft_size & (cfg_fft_size - SIZE_ONE)) == '0) &&
                  (cfg_fft_size >= SIZE_MIN) && (cfg_fft_size <= SIZE_MAX);
    end

    always_comb begin
        idle_nxt  = buf_m_axis_tvalid ? '0 : idle_cnt + 1'b1;
        drain_nxt = drain_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge sync_reset_n) begin
        if (!sync_reset_n) begin
            state_q        <= ST_RESET;
            pending_q      <= SIZE_DEF;
            fft_size       <= SIZE_DEF;
            idle_cnt       <= '0;
            drain_cnt      <= '0;
            phase_cnt      <= '0;
            buf_sync_reset <= 1'b1;
            busy           <= 1'b1;
            cfg_error      <= 1'b0;
            drain_timeout  <= 1'b0;
        end else begin
            cfg_error <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    // cfg_ready is 1 here, so cfg_valid means acceptance.
                    if (cfg_valid) begin
                        if (!size_ok) begin
                            cfg_error <= 1'b1;
                        end else if (cfg_fft_size != fft_size) begin
                            pending_q <= cfg_fft_size;
                            state_q   <= ST_DRAIN;
                            busy      <= 1'b1;
                            idle_cnt  <= '0;
                            drain_cnt <= '0;
                            phase_cnt <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_nxt == DRAIN_LIMIT) begin
                        drain_timeout <= 1'b1;
                    end
                    if ((idle_nxt == IDLE_LIMIT) || (drain_nxt == DRAIN_LIMIT)) begin
                        state_q        <= ST_RESET;
                        fft_size       <= pending_q;
                        buf_sync_reset <= 1'b1;
                        idle_cnt       <= '0;
                        drain_cnt      <= '0;
                        phase_cnt      <= '0;
                    end else begin
                        idle_cnt  <= idle_nxt;
                        drain_cnt <= drain_nxt;
                    end
                end
                ST_RESET: begin
                    if (phase_cnt == RST_LAST) begin
                        state_q        <= ST_SETTLE;
                        buf_sync_reset <= 1'b0;
                        phase_cnt      <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (phase_cnt == SETTLE_LAST) begin
                        state_q   <= ST_RUN;
                        busy      <= 1'b0;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: begin
                    state_q        <= ST_RESET;
                    buf_sync_reset <= 1'b1;
                    busy           <= 1'b1;
                    phase_cnt      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chan_reconfig_ctrl.sv
// Directed bench for chan_reconfig_ctrl with default parameters.
module tb_chan_reconfig_ctrl;

    localparam int DW = 32;
    localparam int FW = 12;

    // ---------------- clock / reset ----------------
    logic clk;
    logic sync_reset_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic          cfg_valid;
    logic [FW-1:0] cfg_fft_size;
    logic          cfg_ready;
    logic          s_axis_tvalid;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tready;
    logic          buf_s_axis_tvalid;
    logic [DW-1:0] buf_s_axis_tdata;
    logic          buf_s_axis_tready;
    logic          buf_m_axis_tvalid;
    logic          buf_m_axis_tready;
    logic          buf_sync_reset;
    logic [FW-1:0] fft_size;
    logic          busy;
    logic          cfg_error;
    logic          drain_timeout;
    logic [1:0]    state;

    chan_reconfig_ctrl dut (
        .clk               (clk),
        .sync_reset_n      (sync_reset_n),
        .cfg_valid         (cfg_valid),
        .cfg_fft_size      (cfg_fft_size),
        .cfg_ready         (cfg_ready),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tready     (s_axis_tready),
        .buf_s_axis_tvalid (buf_s_axis_tvalid),
        .buf_s_axis_tdata  (buf_s_axis_tdata),
        .buf_s_axis_tready (buf_s_axis_tready),
        .buf_m_axis_tvalid (buf_m_axis_tvalid),
        .buf_m_axis_tready (buf_m_axis_tready),
        .buf_sync_reset    (buf_sync_reset),
        .fft_size          (fft_size),
        .busy              (busy),
        .cfg_error         (cfg_error),
        .drain_timeout     (drain_timeout),
        .state             (state)
    );

    localparam logic [31:0] S_RUN    = 32'd0;
    localparam logic [31:0] S_DRAIN  = 32'd1;
    localparam logic [31:0] S_RESET  = 32'd2;
    localparam logic [31:0] S_SETTLE = 32'd3;

    int n_tests = 0;
    int n_fail  = 0;
    int xfer_cnt = 0;
    bit seen_1024 = 1'b0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            s_axis_tdata = s_axis_tdata + 32'h0101_0101;
        end
    endtask

    task automatic send_cfg(input logic [FW-1:0] size);
        cfg_valid    = 1'b1;
        cfg_fft_size = size;
        step(1);
        cfg_valid    = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    // Every upstream handshake must reappear unchanged on the buffer side.
    always @(negedge clk) begin
        if (fft_size == 12'd1024) seen_1024 = 1'b1;
        if (sync_reset_n) begin
            if (s_axis_tvalid && s_axis_tready) begin
                exp_q.push_back(s_axis_tdata);
                xfer_cnt++;
            end
            if (buf_s_axis_tvalid && buf_s_axis_tready) begin
                if (exp_q.size() == 0) check("buf_orphan_xfer", 32'd1, 32'd0);
                else check("buf_data", buf_s_axis_tdata, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int base;
        int early;
        sync_reset_n      = 1'b0;
        cfg_valid         = 1'b0;
        cfg_fft_size      = '0;
        s_axis_tvalid     = 1'b1;
        s_axis_tdata      = 32'h1000_0000;
        buf_s_axis_tready = 1'b1;
        buf_m_axis_tvalid = 1'b0;
        buf_m_axis_tready = 1'b1;
        step(3);

        // Values held during reset
        check("rst_state", 32'(state), S_RESET);
        check("rst_bsr", 32'(buf_sync_reset), 32'd1);
        check("rst_fft_size", 32'(fft_size), 32'd64);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        check("rst_s_tready", 32'(s_axis_tready), 32'd0);
        check("rst_buf_tvalid", 32'(buf_s_axis_tvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_cfg_error", 32'(cfg_error), 32'd0);
        check("rst_drain_to", 32'(drain_timeout), 32'd0);

        // Release with upstream valid: 4 reset cycles, 8 settle, then RUN
        @(negedge clk);
        sync_reset_n = 1'b1;
        step(3);
        check("rel_bsr_3", 32'(buf_sync_reset), 32'd1);
        check("rel_state_3", 32'(state), S_RESET);
        step(1);
        check("rel_bsr_4", 32'(buf_sync_reset), 32'd0);
        check("rel_state_4", 32'(state), S_SETTLE);
        step(7);
        check("rel_state_11", 32'(state), S_SETTLE);
        check("rel_busy_11", 32'(busy), 32'd1);
        check("rel_s_tready_11", 32'(s_axis_tready), 32'd0);
        step(1);
        check("rel_state_12", 32'(state), S_RUN);
        check("rel_busy_12", 32'(busy), 32'd0);
        check("rel_fft_size", 32'(fft_size), 32'd64);
        check("rel_no_xfer", 32'(xfer_cnt), 32'd0);
        check("run_s_tready", 32'(s_axis_tready), 32'd1);
        check("run_buf_tvalid", 32'(buf_s_axis_tvalid), 32'd1);
        check("run_cfg_ready", 32'(cfg_ready), 32'd1);
        check("run_tdata", buf_s_axis_tdata, s_axis_tdata);
        buf_s_axis_tready = 1'b0;
        #1;
        check("run_bp_tready", 32'(s_axis_tready), 32'd0);
        buf_s_axis_tready = 1'b1;
        step(3);

        // Same-size request is a no-op
        send_cfg(12'd64);
        check("same_state", 32'(state), S_RUN);
        check("same_busy", 32'(busy), 32'd0);
        check("same_bsr", 32'(buf_sync_reset), 32'd0);
        check("same_cfg_error", 32'(cfg_error), 32'd0);
        step(2);
        check("same_state_later", 32'(state), S_RUN);

        // 256 with 40 cycles of buffer activity, then 16 idle cycles
        base = xfer_cnt;
        send_cfg(12'd256);
        check("req_cycle_xfer", 32'(xfer_cnt - base), 32'd1);
        check("drain_entry", 32'(state), S_DRAIN);
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_cfg_ready", 32'(cfg_ready), 32'd0);
        check("drain_fft_old", 32'(fft_size), 32'd64);
        check("drain_tdata_pass", buf_s_axis_tdata, s_axis_tdata);
        base = xfer_cnt;
        early = 0;
        for (int i = 0; i < 40; i++) begin
            buf_m_axis_tvalid = i[0];
            step(1);
            if (state != 2'd1) early++;
        end
        check("drain_active_hold", 32'(early), 32'd0);
        buf_m_axis_tvalid = 1'b0;
        n = 0;
        while (state == 2'd1 && n < 100) begin
            step(1);
            n++;
        end
        check("drain_idle_len", 32'(n), 32'd16);
        check("reset_entry", 32'(state), S_RESET);
        check("reset_fft_256", 32'(fft_size), 32'd256);
        check("reset_bsr", 32'(buf_sync_reset), 32'd1);
        step(4);
        check("settle_entry", 32'(state), S_SETTLE);
        check("settle_bsr", 32'(buf_sync_reset), 32'd0);
        step(8);
        check("rerun_state", 32'(state), S_RUN);
        check("rerun_fft", 32'(fft_size), 32'd256);
        check("reconf_blocked", 32'(xfer_cnt - base), 32'd0);
        step(2);

        // Invalid requests: not a power of two, below 8, 4096 truncated to 0
        for (int k = 0; k < 3; k++) begin
            logic [FW-1:0] bad;
            bad = (k == 0) ? 12'd100 : (k == 1) ? 12'd4 : 12'(4096);
            send_cfg(bad);
            check($sformatf("bad%0d_error", k), 32'(cfg_error), 32'd1);
            check($sformatf("bad%0d_state", k), 32'(state), S_RUN);
            step(1);
            check($sformatf("bad%0d_pulse_end", k), 32'(cfg_error), 32'd0);
        end
        check("bad_fft_kept", 32'(fft_size), 32'd256);
        check("bad_busy", 32'(busy), 32'd0);

        // Boundary sizes 8 and 2048 are valid
        send_cfg(12'd8);
        check("min_no_error", 32'(cfg_error), 32'd0);
        check("min_drain", 32'(state), S_DRAIN);
        step(28);
        check("min_run", 32'(state), S_RUN);
        check("min_fft", 32'(fft_size), 32'd8);
        send_cfg(12'd2048);
        check("max_no_error", 32'(cfg_error), 32'd0);
        check("max_drain", 32'(state), S_DRAIN);
        step(28);
        check("max_run", 32'(state), S_RUN);
        check("max_fft", 32'(fft_size), 32'd2048);

        // 512 with buffer output stuck active: drain ends on the timer
        buf_m_axis_tvalid = 1'b1;
        send_cfg(12'd512);
        check("to_drain", 32'(state), S_DRAIN);
        n = 0;
        while (state == 2'd1 && n < 5000) begin
            step(1);
            n++;
        end
        check("to_drain_len", 32'(n), 32'd4096);
        check("to_flag", 32'(drain_timeout), 32'd1);
        check("to_reset", 32'(state), S_RESET);
        check("to_fft", 32'(fft_size), 32'd512);
        buf_m_axis_tvalid = 1'b0;
        step(12);
        check("to_run", 32'(state), S_RUN);
        send_cfg(12'd64);
        step(30);
        check("to_flag_sticky", 32'(drain_timeout), 32'd1);
        check("to_second_fft", 32'(fft_size), 32'd64);
        send_cfg(12'd512);
        step(30);
        check("to_fft_back", 32'(fft_size), 32'd512);

        // Reset mid-DRAIN of a 1024 request discards it
        send_cfg(12'd1024);
        check("abort_drain", 32'(state), S_DRAIN);
        step(5);
        sync_reset_n = 1'b0;
        #1;
        check("abort_state", 32'(state), S_RESET);
        check("abort_fft", 32'(fft_size), 32'd64);
        check("abort_flag_clr", 32'(drain_timeout), 32'd0);
        step(2);
        @(negedge clk);
        sync_reset_n = 1'b1;
        step(12);
        check("abort_run", 32'(state), S_RUN);
        check("abort_fft_run", 32'(fft_size), 32'd64);
        step(40);
        check("abort_fft_later", 32'(fft_size), 32'd64);
        check("never_1024", 32'(seen_1024), 32'd0);

        s_axis_tvalid = 1'b0;
        step(2);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/chan_reconfig_ctrl.md
CHAN_RECONFIG_CTRL -- requirements
Module: chan_reconfig_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 32, stream data width.
- FFT_SIZE_WIDTH, 12, width of the fft_size words.
- DEFAULT_FFT_SIZE, 64, fft_size applied after reset.
- RST_CYCLES, 4, buffer reset pulse length in cycles.
- SETTLE_CYCLES, 8, wait after the buffer reset before traffic reopens.
- IDLE_CYCLES, 16, consecutive output-idle cycles that declare the buffer drained.
- DRAIN_TIMEOUT, 4096, maximum cycles spent in DRAIN.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- sync_reset_n, in, 1, asynchronous active-low reset.
- cfg_valid, in, 1, new size request.
- cfg_fft_size, in, FFT_SIZE_WIDTH, requested size.
- cfg_ready, out, 1, request accepted.
- s_axis_tvalid, in, 1, upstream stream valid.
- s_axis_tdata, in, DATA_WIDTH, upstream stream data.
- s_axis_tready, out, 1, upstream stream ready.
- buf_s_axis_tvalid, out, 1, valid to the input buffer.
- buf_s_axis_tdata, out, DATA_WIDTH, data to the input buffer.
- buf_s_axis_tready, in, 1, ready from the input buffer.
- buf_m_axis_tvalid, in, 1, buffer output valid (monitor only).
- buf_m_axis_tready, in, 1, buffer output ready (monitor only).
- buf_sync_reset, out, 1, active-high reset to the buffer.
- fft_size, out, FFT_SIZE_WIDTH, size driven to the buffer.
- busy, out, 1, high when not in RUN.
- cfg_error, out, 1, one-cycle pulse on an invalid request.
- drain_timeout, out, 1, sticky flag set when DRAIN ends by timeout.

Function
REQ-003 The FSM SHALL have the states RUN, DRAIN, RESET and SETTLE, held in a register.
REQ-004 In RUN, buf_s_axis_tvalid SHALL equal s_axis_tvalid, s_axis_tready SHALL equal buf_s_axis_tready, and buf_s_axis_tdata SHALL equal s_axis_tdata, all combinational with zero latency.
REQ-005 In every state other than RUN, buf_s_axis_tvalid and s_axis_tready SHALL be 0, and the gating SHALL depend only on the registered state.
REQ-006 cfg_ready SHALL equal 1 in RUN and 0 otherwise; a request is accepted when cfg_valid and cfg_ready are both 1.
REQ-007 A request is valid when cfg_fft_size is a power of two, is at least 8, and is at most 2^(FFT_SIZE_WIDTH-1).
REQ-008 On acceptance of an invalid request, cfg_error SHALL pulse 1 on the next cycle and the state SHALL remain RUN.
REQ-009 On acceptance of a valid request equal to the current fft_size, the request SHALL be a no-op and the state SHALL remain RUN.
REQ-010 On acceptance of a valid request that differs from fft_size, the value SHALL be latched into a pending register and the state SHALL go to DRAIN on the next cycle.
REQ-011 An input transfer in the same cycle as an accepted request SHALL complete normally.
REQ-012 In DRAIN, an idle counter SHALL reset to 0 on any cycle with buf_m_axis_tvalid=1, and increment otherwise.
REQ-013 DRAIN SHALL exit to RESET when the idle counter reaches IDLE_CYCLES.
REQ-014 A drain timer SHALL count cycles in DRAIN; when it reaches DRAIN_TIMEOUT, the controller SHALL set drain_timeout and go to RESET, even if the buffer is still active.
REQ-015 On entering RESET, fft_size SHALL load the pending value, buf_sync_reset SHALL be 1 for exactly RST_CYCLES cycles, and then the state SHALL go to SETTLE.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles with buf_sync_reset=0, then the state SHALL go to RUN.
REQ-017 fft_size SHALL change only on the RESET entry cycle.
REQ-018 busy SHALL be the registered inverse of (state==RUN).
REQ-019 The counters SHALL be sized to hold their maximum parameter value without wrap, and SHALL be cleared on every state entry.
REQ-020 drain_timeout SHALL be cleared only by reset.
REQ-021 buf_s_axis_tdata SHALL pass s_axis_tdata through in all states.

Reset
REQ-022 While sync_reset_n=0, the outputs SHALL be: state=RESET, buf_sync_reset=1, fft_size=DEFAULT_FFT_SIZE, cfg_ready=0, s_axis_tready=0, buf_s_axis_tvalid=0, busy=1, cfg_error=0, drain_timeout=0, and all counters 0.
REQ-023 After sync_reset_n rises, buf_sync_reset SHALL stay 1 for RST_CYCLES cycles, followed by SETTLE, then RUN.
REQ-024 Reset asserted in any state, including mid-DRAIN or mid-RESET, SHALL discard the pending size.

Verification
REQ-025 Release reset with s_axis_tvalid=1 -> buf_sync_reset high for 4 cycles, no transfers for 12 cycles, then RUN with fft_size=64 and passthrough active.
REQ-026 In RUN, request 256 while the buffer output toggles for 40 cycles -> DRAIN lasts 40+16 cycles, fft_size becomes 256 at RESET entry, upstream is blocked throughout, and RUN resumes.
REQ-027 Request 100, then 4, then 4096 (with FFT_SIZE_WIDTH=12) -> cfg_error pulses 3 times, fft_size stays unchanged, and the state never leaves RUN.
REQ-028 Request 64 while fft_size=64 -> no busy assertion and no buf_sync_reset pulse.
REQ-029 Request 512 with buf_m_axis_tvalid stuck at 1 -> after 4096 DRAIN cycles drain_timeout=1, the reconfiguration completes, and the flag stays set until reset.
REQ-030 Assert sync_reset_n=0 mid-DRAIN for a 1024 request -> fft_size=64 on release, and 1024 is never applied.
